// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store codes: FSM state encodings and RV32I funct3 width codes.
package lsu_ctrl_pkg;

   typedef enum logic [2:0] {
      LSU_IDLE  = 3'd0,
      LSU_REQ   = 3'd1,
      LSU_WAIT  = 3'd2,
      LSU_DONE  = 3'd3,
      LSU_FAULT = 3'd4
   } lsu_state_e;

   localparam logic [2:0] LSU_F3_B  = 3'b000;
   localparam logic [2:0] LSU_F3_H  = 3'b001;
   localparam logic [2:0] LSU_F3_W  = 3'b010;
   localparam logic [2:0] LSU_F3_BU = 3'b100;
   localparam logic [2:0] LSU_F3_HU = 3'b101;

   // Stores have no unsigned variants, so only B/H/W are legal for them.
   function automatic logic lsu_f3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      ok = (f3 == LSU_F3_B) || (f3 == LSU_F3_H) || (f3 == LSU_F3_W);
      if (!we) ok = ok || (f3 == LSU_F3_BU) || (f3 == LSU_F3_HU);
      return ok;
   endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory port: valid/ready request channel plus response channel.
interface lsu_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_wstrb;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rsp_valid;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
      input  mem_req_ready, mem_rsp_valid, mem_rdata
   );

   modport slave (
      input  mem_req_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
      output mem_req_ready, mem_rsp_valid, mem_rdata
   );
endinterface

// File: rtl/lsu_ctrl_ld_align.sv
// Load data alignment: shift the read word down to the addressed lane, then extend.
module lsu_ld_align
   import lsu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] i_rdata,
   input  logic [1:0]        i_off,
   input  logic [2:0]        i_funct3,
   output logic [DATA_W-1:0] o_ld_data
);

   logic [DATA_W-1:0] w_shifted;

   assign w_shifted = i_rdata >> {i_off, 3'b000};

   always_comb begin
      unique case (i_funct3)
         LSU_F3_B:  o_ld_data = {{(DATA_W-8){w_shifted[7]}}, w_shifted[7:0]};
         LSU_F3_H:  o_ld_data = {{(DATA_W-16){w_shifted[15]}}, w_shifted[15:0]};
         LSU_F3_BU: o_ld_data = {{(DATA_W-8){1'b0}}, w_shifted[7:0]};
         LSU_F3_HU: o_ld_data = {{(DATA_W-16){1'b0}}, w_shifted[15:0]};
         default:   o_ld_data = w_shifted;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between EX/MEM and the data memory port.
// Optional misaligned-access trap (with a misalign output) under LSU_MISALIGN_TRAP_EN.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int RSP_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              lsu_stall,
   output logic              lsu_done,
   output logic [DATA_W-1:0] ld_data,
   output logic              lsu_fault,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic              misalign,
`endif
   lsu_ctrl_if.master        mem
);

   localparam int CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;

   lsu_state_e        r_state;
   logic              r_we, r_req_valid, r_done, r_fault;
   logic [2:0]        r_funct3;
   logic [1:0]        r_off;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_wstrb;
   logic [DATA_W-1:0] r_wdata, r_ld_data;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_tmo, w_f3_ok, w_misalign, w_trap;
   logic [3:0]        w_wstrb;
   logic [DATA_W-1:0] w_wdata, w_ld_fmt;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      w_wstrb = 4'b0000;
      w_wdata = '0;
      if (req_we) begin
         unique case (req_funct3[1:0])
            2'b00:   begin w_wstrb = 4'b0001 << req_addr[1:0]; w_wdata = {4{req_wdata[7:0]}};  end
            2'b01:   begin w_wstrb = 4'b0011 << req_addr[1:0]; w_wdata = {2{req_wdata[15:0]}}; end
            default: begin w_wstrb = 4'b1111;                  w_wdata = req_wdata;            end
         endcase
      end
   end

   assign w_f3_ok = lsu_f3_legal(req_we, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
   assign w_misalign = w_f3_ok &&
                       (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
`else
   assign w_misalign = 1'b0;
`endif
   assign w_trap    = !w_f3_ok || w_misalign;
   assign w_cnt_nxt = r_cnt + CNT_W'(1);
   assign w_tmo     = (RSP_TIMEOUT != 0) && (w_cnt_nxt == CNT_W'(RSP_TIMEOUT));

   lsu_ld_align #(.DATA_W(DATA_W)) u_ld_align (
      .i_rdata   (mem.mem_rdata),
      .i_off     (r_off),
      .i_funct3  (r_funct3),
      .o_ld_data (w_ld_fmt)
   );

`ifdef LSU_MISALIGN_TRAP_EN
   logic r_misalign;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                           r_misalign <= 1'b0;
      else if ((r_state == LSU_IDLE) && req_valid && w_trap) r_misalign <= w_misalign;
      else                                                  r_misalign <= 1'b0;
   end
   assign misalign = r_misalign;
`endif

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= LSU_IDLE;
         r_we        <= 1'b0;
         r_funct3    <= 3'b000;
         r_off       <= 2'b00;
         r_addr      <= '0;
         r_wstrb     <= 4'b0000;
         r_wdata     <= '0;
         r_ld_data   <= '0;
         r_cnt       <= '0;
         r_req_valid <= 1'b0;
         r_done      <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_fault <= 1'b0;
         unique case (r_state)
            LSU_IDLE: if (req_valid) begin
               r_we     <= req_we;
               r_funct3 <= req_funct3;
               r_off    <= req_addr[1:0];
               r_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
               r_wstrb  <= w_wstrb;
               r_wdata  <= w_wdata;
               r_cnt    <= '0;
               if (w_trap) begin
                  r_fault <= 1'b1;
                  r_state <= LSU_FAULT;
               end else begin
                  r_req_valid <= 1'b1;
                  r_state     <= LSU_REQ;
               end
            end
            LSU_REQ: if (mem.mem_req_ready) begin
               r_req_valid <= 1'b0;
               r_state     <= LSU_WAIT;
            end
            // Response wins over a timeout landing in the same cycle.
            LSU_WAIT: if (mem.mem_rsp_valid) begin
               if (!r_we) r_ld_data <= w_ld_fmt;
               r_done  <= 1'b1;
               r_state <= LSU_DONE;
            end else if (w_tmo) begin
               r_fault <= 1'b1;
               r_state <= LSU_FAULT;
            end else begin
               r_cnt <= w_cnt_nxt;
            end
            default: r_state <= LSU_IDLE;
         endcase
      end
   end

   assign lsu_stall = ((r_state == LSU_IDLE) && req_valid) ||
                      (r_state == LSU_REQ) || (r_state == LSU_WAIT);
   assign lsu_done  = r_done;
   assign lsu_fault = r_fault;
   assign ld_data   = r_ld_data;

   assign mem.mem_req_valid = r_req_valid;
   assign mem.mem_we        = r_we;
   assign mem.mem_addr      = r_addr;
   assign mem.mem_wstrb     = r_wstrb;
   assign mem.mem_wdata     = r_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: transaction-level timeline model, per-cycle compare, directed pins.
module tb_lsu_ctrl;

   localparam int TMO = 4;

   typedef struct packed {
      logic        stall, req_v, done, fault, mis, chk_bus, we, chk_ld;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [31:0] ld;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        lsu_stall, lsu_done, lsu_fault;
   logic [31:0] ld_data;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   lsu_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

   lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .RSP_TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .lsu_stall  (lsu_stall),
      .lsu_done   (lsu_done),
      .ld_data    (ld_data),
      .lsu_fault  (lsu_fault),
`ifdef LSU_MISALIGN_TRAP_EN
      .misalign   (misalign),
`endif
      .mem        (mem_if)
   );

   always #5 clk = ~clk;

   int   n_checks = 0, n_pass = 0;
   int   cyc = 0, acc_cyc = 0, done_cyc = 0, fault_cyc = 0;
   int   n_done = 0, n_fault = 0, n_reqv = 0, n_mis = 0;
   logic [31:0] obs_addr, obs_wdata;
   logic [3:0]  obs_strb;
   exp_t exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
      else n_pass++;
   endtask

   // ---------------- behavioural model ----------------
   function automatic int nbytes(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit f3_ok(input logic we, input logic [2:0] f3);
      if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
   endfunction

   function automatic bit is_mis(input logic we, input logic [2:0] f3, input logic [1:0] off);
`ifdef LSU_MISALIGN_TRAP_EN
      if (!f3_ok(we, f3)) return 1'b0;
      return ((nbytes(f3) == 2) && off[0]) || ((nbytes(f3) == 4) && (off != 2'b00));
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] m_strb(input logic we, input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] s = 4'b0000;
      int n = nbytes(f3);
      int base = (n == 4) ? 0 : int'(off);
      if (!we) return 4'b0000;
      for (int i = 0; i < 4; i++) if (i >= base && i < base + n) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      int n = nbytes(f3);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
      logic [31:0] v, mask;
      int n = nbytes(f3);
      bit neg;
      v = rd >> (8 * int'(off));
      if (n == 4) return v;
      mask = (32'd1 << (8 * n)) - 32'd1;
      neg  = !f3[2] && v[8*n-1];
      v    = v & mask;
      if (neg) v = v | ~mask;
      return v;
   endfunction

   // ---------------- drive helpers ----------------
   task automatic step(input exp_t e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic junk_req();
      req_valid  = 1'($urandom_range(0, 1));
      req_we     = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr   = $urandom;
      req_wdata  = $urandom;
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
      mem_if.mem_req_ready = 1'b0; mem_if.mem_rsp_valid = 1'b0; mem_if.mem_rdata = '0;
   endtask

   // One full transaction; rsp_dly = 0 means the memory never answers.
   task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input int rdy_dly, input int rsp_dly, input bit rsp_hs);
      exp_t e;
      int   n_wait;
      acc_cyc = cyc;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      mem_if.mem_req_ready = 1'b0; mem_if.mem_rsp_valid = 1'b0; mem_if.mem_rdata = $urandom;
      e = '0; e.stall = 1'b1;
      step(e);
      if (!f3_ok(we, f3) || is_mis(we, f3, addr[1:0])) begin
         junk_req();
         e = '0; e.fault = 1'b1; e.mis = is_mis(we, f3, addr[1:0]);
         step(e);
      end else begin
         for (int i = 0; i <= rdy_dly; i++) begin
            junk_req();
            mem_if.mem_req_ready = (i == rdy_dly);
            mem_if.mem_rsp_valid = (i == rdy_dly) ? rsp_hs : 1'($urandom_range(0, 1));
            mem_if.mem_rdata     = $urandom;
            e = '0; e.stall = 1'b1; e.req_v = 1'b1; e.chk_bus = 1'b1; e.we = we;
            e.addr  = addr & 32'hFFFF_FFFC;
            e.strb  = m_strb(we, f3, addr[1:0]);
            e.wdata = m_wdata(f3, wd);
            step(e);
         end
         n_wait = (rsp_dly == 0) ? TMO : rsp_dly;
         for (int j = 1; j <= n_wait; j++) begin
            junk_req();
            mem_if.mem_req_ready = 1'($urandom_range(0, 1));
            mem_if.mem_rsp_valid = (rsp_dly != 0) && (j == rsp_dly);
            mem_if.mem_rdata     = mem_if.mem_rsp_valid ? rd : $urandom;
            e = '0; e.stall = 1'b1;
            step(e);
         end
         junk_req();
         mem_if.mem_rsp_valid = 1'($urandom_range(0, 1));
         mem_if.mem_rdata     = $urandom;
         e = '0;
         if (rsp_dly == 0) e.fault = 1'b1;
         else begin
            e.done   = 1'b1;
            e.chk_ld = !we;
            e.ld     = m_ld(f3, addr[1:0], rd);
         end
         step(e);
      end
   endtask

   // ---------------- compare / monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("lsu_stall", {31'd0, lsu_stall}, {31'd0, e.stall});
            check("mem_req_valid", {31'd0, mem_if.mem_req_valid}, {31'd0, e.req_v});
            check("lsu_done", {31'd0, lsu_done}, {31'd0, e.done});
            check("lsu_fault", {31'd0, lsu_fault}, {31'd0, e.fault});
`ifdef LSU_MISALIGN_TRAP_EN
            check("misalign", {31'd0, misalign}, {31'd0, e.mis});
`endif
            if (e.chk_bus) begin
               check("mem_addr", mem_if.mem_addr, e.addr);
               check("mem_wstrb", {28'd0, mem_if.mem_wstrb}, {28'd0, e.strb});
               check("mem_we", {31'd0, mem_if.mem_we}, {31'd0, e.we});
               if (e.we) check("mem_wdata", mem_if.mem_wdata, e.wdata);
            end
            if (e.chk_ld) check("ld_data", ld_data, e.ld);
         end
         if (lsu_done)  begin n_done++;  done_cyc  = cyc; end
         if (lsu_fault) begin n_fault++; fault_cyc = cyc; end
         if (mem_if.mem_req_valid) begin
            n_reqv++;
            obs_addr  = mem_if.mem_addr;
            obs_strb  = mem_if.mem_wstrb;
            obs_wdata = mem_if.mem_wdata;
         end
`ifdef LSU_MISALIGN_TRAP_EN
         if (misalign) n_mis++;
`endif
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      exp_t z;
      int   d0, f0, r0, m0;
      logic we;
      logic [2:0] f3;
      z = '0;
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", {31'd0, lsu_stall}, 32'd0);
      check("rst_req_valid", {31'd0, mem_if.mem_req_valid}, 32'd0);
      check("rst_done", {31'd0, lsu_done}, 32'd0);
      check("rst_fault", {31'd0, lsu_fault}, 32'd0);
      check("rst_mem_addr", mem_if.mem_addr, 32'd0);
      check("rst_ld_data", ld_data, 32'd0);
      rst_n = 1'b1;
      step(z);

      // SB to byte lane 2
      d0 = n_done;
      txn(1'b1, 3'b000, 32'h0000_1002, 32'h5555_55AB, $urandom, 0, 1, 1'b0);
      check("sb_addr", obs_addr, 32'h0000_1000);
      check("sb_wstrb", {28'd0, obs_strb}, 32'h4);
      check("sb_wdata", obs_wdata, 32'hABAB_ABAB);
      check("sb_latency", done_cyc - acc_cyc, 32'd3);
      check("sb_done_cnt", n_done - d0, 32'd1);

      // LB / LBU from lane 1
      txn(1'b0, 3'b000, 32'h0000_2001, '0, 32'h0000_80FF, 0, 1, 1'b0);
      check("lb_ld", ld_data, 32'hFFFF_FF80);
      txn(1'b0, 3'b100, 32'h0000_2001, '0, 32'h0000_80FF, 0, 1, 1'b0);
      check("lbu_ld", ld_data, 32'h0000_0080);

      // LH with ready held low for 5 cycles
      d0 = n_done; r0 = n_reqv;
      txn(1'b0, 3'b001, 32'h0000_3002, '0, 32'h8001_0000, 5, 1, 1'b0);
      check("lh_ld", ld_data, 32'hFFFF_8001);
      check("lh_req_cycles", n_reqv - r0, 32'd6);
      check("lh_done_cnt", n_done - d0, 32'd1);
      check("lh_addr", obs_addr, 32'h0000_3000);

      // Response timeout
      d0 = n_done; f0 = n_fault;
      txn(1'b0, 3'b010, 32'h0000_6000, '0, '0, 0, 0, 1'b0);
      check("tmo_fault_cnt", n_fault - f0, 32'd1);
      check("tmo_done_cnt", n_done - d0, 32'd0);
      check("tmo_latency", fault_cyc - acc_cyc, 32'd6);

      // Reset asserted while waiting for a response
      d0 = n_done; f0 = n_fault;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_5000;
      z.stall = 1'b1;
      step(z);
      req_valid = 1'b0; mem_if.mem_req_ready = 1'b1;
      z = '0; z.stall = 1'b1; z.req_v = 1'b1; z.chk_bus = 1'b1; z.addr = 32'h0000_5000;
      step(z);
      mem_if.mem_req_ready = 1'b0; mem_if.mem_rsp_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_stall", {31'd0, lsu_stall}, 32'd0);
      check("midrst_mem_addr", mem_if.mem_addr, 32'd0);
      check("midrst_ld_data", ld_data, 32'd0);
      z = '0;
      step(z);
      step(z);
      rst_n = 1'b1;
      step(z);
      check("midrst_no_done", n_done - d0, 32'd0);
      check("midrst_no_fault", n_fault - f0, 32'd0);
      d0 = n_done;
      txn(1'b0, 3'b010, 32'h0000_7000, '0, 32'h1234_5678, 1, 2, 1'b1);
      check("postrst_ld", ld_data, 32'h1234_5678);
      check("postrst_done_cnt", n_done - d0, 32'd1);

      // Illegal funct3 for a load and for a store
      f0 = n_fault; r0 = n_reqv;
      txn(1'b0, 3'b011, 32'h0000_8000, '0, '0, 0, 1, 1'b0);
      txn(1'b1, 3'b100, 32'h0000_8004, 32'h1, '0, 0, 1, 1'b0);
      check("bad_f3_faults", n_fault - f0, 32'd2);
      check("bad_f3_no_req", n_reqv - r0, 32'd0);

      // Misaligned LW
      f0 = n_fault; r0 = n_reqv; m0 = n_mis;
      txn(1'b0, 3'b010, 32'h0000_4002, '0, 32'hCAFE_BABE, 0, 1, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("lw_mis_flag", n_mis - m0, 32'd1);
      check("lw_mis_fault", n_fault - f0, 32'd1);
      check("lw_mis_no_req", n_reqv - r0, 32'd0);
`else
      check("lw_mis_addr", obs_addr, 32'h0000_4000);
      check("lw_mis_ld", ld_data, 32'h0000_CAFE);
      check("lw_mis_no_fault", n_fault - f0, 32'd0);
`endif

      // Randomized traffic
      for (int k = 0; k < 80; k++) begin
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
         else if (we)                   f3 = 3'($urandom_range(0, 2));
         else begin
            f3 = 3'($urandom_range(0, 4));
            if (f3 == 3'd3) f3 = 3'd5;
         end
         txn(we, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3),
             ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO),
             1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            req_valid = 1'b0;
            step(z);
         end
      end
      req_valid = 1'b0;
      step(z);
      step(z);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the EX/MEM stage and the data memory port.
- Accepts one decoded load/store per transaction, then drives a valid/ready request channel and waits for the response.
- Forms byte strobes and lane-shifted write data; aligns and sign/zero-extends read data.
- Asserts a pipeline stall while a transaction is in flight.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, memory data width; fixed at 32, four byte lanes.
- RSP_TIMEOUT, 255, cycles in WAIT_RSP before an access fault is raised; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  EX stage presents a load/store.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address from the ALU ADD result.
- req_wdata  in  DATA_W  rs2 value, LSB-justified.
- lsu_stall  out  1  hold the pipeline.
- lsu_done  out  1  one-cycle completion pulse.
- ld_data  out  DATA_W  extended load result; valid when lsu_done=1 and the op is a load.
- lsu_fault  out  1  one-cycle pulse: bad funct3, timeout, or misalign (option).
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word address: low 2 bits forced to 00.
- mem_wstrb  out  4  byte lane strobes.
- mem_wdata  out  DATA_W  lane-shifted store data.
- mem_rsp_valid  in  1  read data or write acknowledge.
- mem_rdata  in  DATA_W  read word.

Behaviour:
- Reset values: state=IDLE; all outputs 0; the latched request and the timeout counter cleared.
- Reset is asynchronous and may assert mid-transaction. The FSM returns to IDLE and no done or fault pulse is produced. The memory side must tolerate the abandoned request.

FSM states and transitions:
- IDLE:
  - If req_valid=1, latch we, funct3, addr, wdata.
  - Illegal funct3 (011, 110, 111; for stores, anything other than 000/001/010) -> FAULT.
  - Otherwise -> REQ.
- REQ:
  - mem_req_valid=1 with stable addr, we, wstrb, wdata.
  - Advance to WAIT_RSP only on mem_req_valid and mem_req_ready both high.
  - Valid is never dropped before ready.
- WAIT_RSP:
  - On mem_rsp_valid -> DONE; capture the formatted load data.
  - A response arriving in the same cycle as the handshake is ignored. Responses count only in WAIT_RSP.
  - The counter increments each cycle. If it reaches RSP_TIMEOUT (when nonzero) -> FAULT.
- DONE: lsu_done=1 for one cycle -> IDLE.
- FAULT: lsu_fault=1 for one cycle -> IDLE.

Stall and acceptance:
- lsu_stall = (state==IDLE and req_valid) or state in {REQ, WAIT_RSP}.
- lsu_stall is 0 in DONE and FAULT, so the pipeline advances on the completion cycle.
- req_valid in DONE/FAULT is not accepted; it is re-sampled in IDLE on the next cycle.

Latency:
- Minimum latency is request accept to lsu_done = 3 cycles (IDLE -> REQ -> WAIT_RSP -> DONE), with ready and response each arriving after one cycle.

Store strobes and data (off = addr[1:0]):
- B: wstrb = 0001<<off; wdata = {4{wdata[7:0]}}.
- H: wstrb = 0011<<off; wdata = {2{wdata[15:0]}}.
- W: wstrb = 1111; wdata unchanged.
- Loads: wstrb = 0000.

Load data formatting:
- Shift rdata right by 8*off.
- B/H: sign-extend from bit 7/15.
- BU/HU: zero-extend.
- W: pass through.

Misalignment (option off):
- H with off=3 and W with off≠0 truncate to the lanes in range.
- No fault is raised.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - H with addr[0]=1, or W with addr[1:0]≠00, goes IDLE -> FAULT.
  - No memory request is issued.
  - Additional output misalign out 1 pulses together with lsu_fault.
- Undefined:
  - Port absent; truncation behaviour as in Behaviour.

Decomposition:
- Shared header, same file as the ALU op/control codes:
  - FSM state encodings LSU_IDLE/REQ/WAIT/DONE/FAULT, 3 bits.
  - funct3 width codes LSU_F3_B/H/W/BU/HU.
- One sub-module, lsu_ld_align: combinational rdata shift and extend (rdata, off, funct3 -> ld_data).
- lsu_ctrl holds the FSM, the latches, strobe generation and the timeout counter.

Test Plan:
- SB addr=0x1002, wdata=0xAB, ready and response after 1 cycle -> mem_addr=0x1000, wstrb=0100, wdata=0xABABABAB, lsu_done 3 cycles after accept.
- LB addr=0x2001, rdata=0x0000_80FF -> ld_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
- LH addr=0x3002, mem_req_ready held low 5 cycles -> mem_req_valid and addr stable throughout, lsu_stall=1, lsu_done once after the response, rdata 0x8001_0000 -> ld_data=0xFFFF8001.
- Load with no response, RSP_TIMEOUT=4 -> lsu_fault pulses after 4 WAIT_RSP cycles, state returns to IDLE, lsu_done never asserted.
- rst_n low during WAIT_RSP -> all outputs 0 immediately, next request proceeds normally; funct3=011 -> lsu_fault, no mem_req_valid.
- LW addr=0x4002 -> with LSU_MISALIGN_TRAP_EN: misalign=1, lsu_fault=1, no request; without: mem_addr=0x4000, ld_data=rdata>>16.
